// File: rtl/mem_responder_pkg.sv
// Shared types and default widths for the byte-serial word memory responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int ADDR_W_DEF = 8;
  localparam int BYTE_W_DEF = 8;
  localparam int WORD_W_DEF = 2 * BYTE_W_DEF;

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port byte RAM: synchronous write, registered read data, contents never reset.
module mem_byte_ram #(
  parameter int ADDR_W = 8,
  parameter int BYTE_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem_q [2**ADDR_W];
  logic [BYTE_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Word-access responder over a byte RAM: big-endian, two byte cycles per access,
// fixed latency, with a byte preload port that only gets the RAM when idle.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [BYTE_W-1:0] ld_data,
  output logic [WORD_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  if (WORD_W != 2 * BYTE_W) begin : g_width_check
    $error("mem_responder: WORD_W must equal 2*BYTE_W");
  end

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] lo_addr;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [BYTE_W-1:0] ram_wdata;
  logic [BYTE_W-1:0] ram_rdata;

  // Low byte lives at addr+1, wrapping at the top of the array.
  assign lo_addr = addr_q + ADDR_W'(1);

  // RAM port arbitration: access FSM owns it in HI/LO; preload only when idle with no request.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = ld_addr;
    ram_wdata = ld_data;
    case (state_q)
      IDLE: ram_we = ld_en & ~req;
      HI: begin
        ram_addr  = addr_q;
        ram_we    = we_q;
        ram_wdata = wdata_q[WORD_W-1 -: BYTE_W];
      end
      LO: begin
        ram_addr  = lo_addr;
        ram_we    = we_q;
        ram_wdata = wdata_q[BYTE_W-1:0];
      end
      default: ram_we = 1'b0;
    endcase
    if (reset) begin
      ram_we = 1'b0;
    end
  end

  mem_byte_ram #(
    .ADDR_W (ADDR_W),
    .BYTE_W (BYTE_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM read data is one cycle behind the address: high byte appears in LO, low byte in DONE.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = HI;
        end
      end
      HI:   state_d = LO;
      LO: begin
        hi_d    = ram_rdata;
        state_d = DONE;
      end
      DONE: begin
        ack_d   = 1'b1;
        state_d = IDLE;
        if (!we_q) begin
          rdata_d = {hi_q, ram_rdata};
        end
      end
      default: state_d = IDLE;
    endcase
    if (req && state_q != IDLE) begin
      err_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    hi_q    <= hi_d;
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule
